// File: rtl/bpred_resolve_queue.sv
// In-order branch checkpoint queue: resolves branches against the oldest entry and
// produces predictor update, fetch redirect and GHR/RAS recovery. Stats via BPRED_RQ_STATS_EN.
module bpred_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int GHR_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             f_push,
    input  logic [31:0]      f_PC4,
    input  logic             f_p_dir,
    input  logic [31:0]      f_p_target,
    input  logic [3:0]       f_ras_index,
    input  logic [GHR_W-1:0] f_ghr,
    output logic             f_full,
    input  logic             e_resolve,
    input  logic             e_dir,
    input  logic [31:0]      e_target,
    output logic             e_ready,
    input  logic             soin_bpredictor_stall,
    output logic             execute_bpredictor_update,
    output logic [31:0]      execute_bpredictor_PC4,
    output logic [31:0]      execute_bpredictor_target,
    output logic             execute_bpredictor_dir,
    output logic             execute_bpredictor_miss,
    output logic             execute_bpredictor_recover_ras,
    output logic [3:0]       execute_bpredictor_meta,
    output logic             fetch_redirect,
    output logic [31:0]      fetch_redirect_PC,
    output logic             ghr_restore,
    output logic [GHR_W-1:0] ghr_restore_val,
    output logic             q_err,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_misses
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr, rd_ptr, count;
    logic [31:0]      pc4_mem    [DEPTH];
    logic             pdir_mem   [DEPTH];
    logic [31:0]      ptgt_mem   [DEPTH];
    logic [3:0]       ras_mem    [DEPTH];
    logic [GHR_W-1:0] ghr_mem    [DEPTH];

    logic [AW-1:0]    head_idx;
    logic             accept, empty, pop, miss, flush, push;

    assign count    = wr_ptr - rd_ptr;
    assign f_full   = (count == PW'(DEPTH));
    assign e_ready  = ~soin_bpredictor_stall;
    assign empty    = (count == '0);
    assign accept   = e_resolve & e_ready;
    assign pop      = accept & ~empty;
    assign head_idx = rd_ptr[AW-1:0];

    assign miss  = (e_dir != pdir_mem[head_idx]) |
                   (e_dir & (e_target != ptgt_mem[head_idx]));
    assign flush = pop & miss;
    // A mispredict makes every younger entry (and any same-cycle push) wrong-path.
    assign push  = f_push & ~f_full & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (flush)
                wr_ptr <= rd_ptr + PW'(1);
            else if (push)
                wr_ptr <= wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc4_mem[wr_ptr[AW-1:0]]  <= f_PC4;
            pdir_mem[wr_ptr[AW-1:0]] <= f_p_dir;
            ptgt_mem[wr_ptr[AW-1:0]] <= f_p_target;
            ras_mem[wr_ptr[AW-1:0]]  <= f_ras_index;
            ghr_mem[wr_ptr[AW-1:0]]  <= f_ghr;
        end
    end

    // Pulse outputs follow pop; data outputs hold whenever nothing is popped (incl. stall).
    always_ff @(posedge clk) begin
        if (reset) begin
            execute_bpredictor_update      <= 1'b0;
            execute_bpredictor_PC4         <= '0;
            execute_bpredictor_target      <= '0;
            execute_bpredictor_dir         <= 1'b0;
            execute_bpredictor_miss        <= 1'b0;
            execute_bpredictor_recover_ras <= 1'b0;
            execute_bpredictor_meta        <= '0;
            fetch_redirect                 <= 1'b0;
            fetch_redirect_PC              <= '0;
            ghr_restore                    <= 1'b0;
            ghr_restore_val                <= '0;
            q_err                          <= 1'b0;
        end else begin
            execute_bpredictor_update <= pop;
            fetch_redirect            <= flush;
            ghr_restore               <= flush;
            if (accept & empty)
                q_err <= 1'b1;
            if (pop) begin
                execute_bpredictor_PC4         <= pc4_mem[head_idx];
                execute_bpredictor_target      <= e_target;
                execute_bpredictor_dir         <= e_dir;
                execute_bpredictor_miss        <= miss;
                execute_bpredictor_recover_ras <= miss;
                execute_bpredictor_meta        <= ras_mem[head_idx];
            end
            if (flush) begin
                fetch_redirect_PC <= e_dir ? e_target : pc4_mem[head_idx];
                ghr_restore_val   <= {ghr_mem[head_idx][GHR_W-2:0], e_dir};
            end
        end
    end

`ifdef BPRED_RQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches <= '0;
            stat_misses   <= '0;
        end else begin
            if (pop && stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (flush && stat_misses != 32'hFFFF_FFFF)
                stat_misses <= stat_misses + 32'd1;
        end
    end
`else
    assign stat_branches = '0;
    assign stat_misses   = '0;
`endif

endmodule

// File: tb/tb_bpred_resolve_queue.sv
// Scoreboard bench for bpred_resolve_queue: a queue-based reference model predicts each
// update bundle; a negedge monitor compares whatever the DUT presents.
module tb_bpred_resolve_queue;
    localparam int DEPTH = 8;
    localparam int GHR_W = 12;

    logic             clk = 1'b0;
    logic             reset;
    logic             f_push;
    logic [31:0]      f_PC4;
    logic             f_p_dir;
    logic [31:0]      f_p_target;
    logic [3:0]       f_ras_index;
    logic [GHR_W-1:0] f_ghr;
    logic             f_full;
    logic             e_resolve;
    logic             e_dir;
    logic [31:0]      e_target;
    logic             e_ready;
    logic             soin_bpredictor_stall;
    logic             upd;
    logic [31:0]      upd_pc4, upd_tgt;
    logic             upd_dir, upd_miss, upd_rras;
    logic [3:0]       upd_meta;
    logic             fetch_redirect;
    logic [31:0]      fetch_redirect_PC;
    logic             ghr_restore;
    logic [GHR_W-1:0] ghr_restore_val;
    logic             q_err;
    logic [31:0]      stat_branches, stat_misses;

    bpred_resolve_queue #(.DEPTH(DEPTH), .GHR_W(GHR_W)) dut (
        .clk(clk), .reset(reset),
        .f_push(f_push), .f_PC4(f_PC4), .f_p_dir(f_p_dir), .f_p_target(f_p_target),
        .f_ras_index(f_ras_index), .f_ghr(f_ghr), .f_full(f_full),
        .e_resolve(e_resolve), .e_dir(e_dir), .e_target(e_target), .e_ready(e_ready),
        .soin_bpredictor_stall(soin_bpredictor_stall),
        .execute_bpredictor_update(upd), .execute_bpredictor_PC4(upd_pc4),
        .execute_bpredictor_target(upd_tgt), .execute_bpredictor_dir(upd_dir),
        .execute_bpredictor_miss(upd_miss), .execute_bpredictor_recover_ras(upd_rras),
        .execute_bpredictor_meta(upd_meta),
        .fetch_redirect(fetch_redirect), .fetch_redirect_PC(fetch_redirect_PC),
        .ghr_restore(ghr_restore), .ghr_restore_val(ghr_restore_val),
        .q_err(q_err), .stat_branches(stat_branches), .stat_misses(stat_misses)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      pc4;
        logic             dir;
        logic [31:0]      tgt;
        logic [3:0]       ras;
        logic [GHR_W-1:0] ghr;
    } ent_t;

    typedef struct {
        int               due;
        logic [31:0]      pc4;
        logic [31:0]      tgt;
        logic             dir;
        logic             miss;
        logic [3:0]       meta;
        logic [31:0]      rpc;
        logic [GHR_W-1:0] gval;
    } exp_t;

    ent_t        mq[$];
    exp_t        sb[$];
    logic        m_qerr;
    logic [31:0] m_branches, m_misses;
    int          cyc = 0;
    bit          mon_en = 0;
    int          compared = 0;
    int          mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // State visible before the next stimulus is driven.
    task automatic checkOutput();
        check("f_full", 32'(f_full), 32'(mq.size() == DEPTH));
        check("e_ready", 32'(e_ready), 32'(!soin_bpredictor_stall));
        check("q_err", 32'(q_err), 32'(m_qerr));
`ifdef BPRED_RQ_STATS_EN
        check("stat_branches", stat_branches, m_branches);
        check("stat_misses", stat_misses, m_misses);
`else
        check("stat_branches", stat_branches, 32'd0);
        check("stat_misses", stat_misses, 32'd0);
`endif
    endtask

    task automatic applyStimulus(input logic rst, input logic push, input logic [31:0] pc4,
                                 input logic pdir, input logic [31:0] ptgt, input logic [3:0] ras,
                                 input logic [GHR_W-1:0] ghr, input logic resolve,
                                 input logic edir, input logic [31:0] etgt, input logic stall);
        ent_t h;
        exp_t e;
        bit   was_full, flushed, mis;
        @(negedge clk);
        checkOutput();
        reset = rst; f_push = push; f_PC4 = pc4; f_p_dir = pdir; f_p_target = ptgt;
        f_ras_index = ras; f_ghr = ghr; e_resolve = resolve; e_dir = edir; e_target = etgt;
        soin_bpredictor_stall = stall;
        if (rst) begin
            mq.delete();
            m_qerr = 0; m_branches = 0; m_misses = 0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        flushed = 0;
        if (resolve && !stall) begin
            if (mq.size() == 0) begin
                m_qerr = 1;
            end else begin
                h = mq.pop_front();
                mis = (edir != h.dir) || (edir && etgt != h.tgt);
                e.due = cyc + 1; e.pc4 = h.pc4; e.tgt = etgt; e.dir = edir; e.miss = mis;
                e.meta = h.ras;
                e.rpc = edir ? etgt : h.pc4;
                e.gval = GHR_W'((h.ghr << 1) | GHR_W'(edir));
                sb.push_back(e);
                if (m_branches != 32'hFFFF_FFFF) m_branches++;
                if (mis) begin
                    if (m_misses != 32'hFFFF_FFFF) m_misses++;
                    mq.delete();
                    flushed = 1;
                end
            end
        end
        if (push && !was_full && !flushed) begin
            h.pc4 = pc4; h.dir = pdir; h.tgt = ptgt; h.ras = ras; h.ghr = ghr;
            mq.push_back(h);
        end
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic pushB(input logic [31:0] pc4, input logic pdir, input logic [31:0] ptgt,
                         input logic [3:0] ras, input logic [GHR_W-1:0] ghr);
        applyStimulus(0, 1, pc4, pdir, ptgt, ras, ghr, 0, 0, 0, 0);
    endtask
    task automatic resolveB(input logic edir, input logic [31:0] etgt);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, edir, etgt, 0);
    endtask

    // Monitor: an update must appear exactly when the scoreboard head is due, never otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("update", 32'(upd), 32'd1);
                check("upd_pc4", upd_pc4, e.pc4);
                check("upd_target", upd_tgt, e.tgt);
                check("upd_dir", 32'(upd_dir), 32'(e.dir));
                check("upd_miss", 32'(upd_miss), 32'(e.miss));
                check("recover_ras", 32'(upd_rras), 32'(e.miss));
                check("meta", 32'(upd_meta), 32'(e.meta));
                check("redirect", 32'(fetch_redirect), 32'(e.miss));
                check("ghr_restore", 32'(ghr_restore), 32'(e.miss));
                if (e.miss) begin
                    check("redirect_pc", fetch_redirect_PC, e.rpc);
                    check("ghr_val", 32'(ghr_restore_val), 32'(e.gval));
                end
            end else begin
                check("idle_update", 32'(upd), 32'd0);
                check("idle_redirect", 32'(fetch_redirect), 32'd0);
                check("idle_ghr_restore", 32'(ghr_restore), 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] rt;
        logic        rd;
        reset = 1; f_push = 0; f_PC4 = 0; f_p_dir = 0; f_p_target = 0; f_ras_index = 0;
        f_ghr = 0; e_resolve = 0; e_dir = 0; e_target = 0; soin_bpredictor_stall = 0;
        m_qerr = 0; m_branches = 0; m_misses = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        check("rst_pc4", upd_pc4, 32'd0);
        check("rst_meta", 32'(upd_meta), 32'd0);
        check("rst_redirect_pc", fetch_redirect_PC, 32'd0);
        mon_en = 1;

        // Three correctly predicted branches.
        pushB(32'h104, 0, 32'h0, 4'd1, 12'h001);
        pushB(32'h204, 1, 32'h400, 4'd2, 12'h002);
        pushB(32'h304, 0, 32'h0, 4'd3, 12'h003);
        resolveB(0, 32'h0);
        resolveB(1, 32'h400);
        resolveB(0, 32'h0);
        idle(); idle();

        // Mispredict with two younger entries that must never be reported.
        pushB(32'h104, 0, 32'h0, 4'd5, 12'hABC);
        pushB(32'h208, 1, 32'h900, 4'd6, 12'h111);
        pushB(32'h30C, 0, 32'h0, 4'd7, 12'h222);
        resolveB(1, 32'h800);
        idle();
        check("dir_redirect_pc", fetch_redirect_PC, 32'h800);
        check("dir_ghr_val", 32'(ghr_restore_val), 32'h579);
        check("dir_meta", 32'(upd_meta), 32'd5);
        idle();
        check("dir_empty_full", 32'(f_full), 32'd0);

        // Resolve on empty queue sets the sticky error.
        resolveB(0, 32'h0);
        idle(); idle(); idle();
        check("dir_qerr_sticky", 32'(q_err), 32'd1);

        // Fill, overflow, then push+pop together across pointer wrap.
        for (int i = 0; i < DEPTH + 1; i++)
            pushB(32'h1000 + 32'(i) * 4, 0, 32'h0, 4'(i), GHR_W'(i));
        check("dir_full", 32'(f_full), 32'd1);
        resolveB(0, 32'h0);
        applyStimulus(0, 1, 32'h2000, 1, 32'h2400, 4'd9, 12'h0F0, 1, 0, 32'h0, 0);
        pushB(32'h2004, 0, 32'h0, 4'd10, 12'h0F1);
        while (mq.size() > 0)
            resolveB(mq[0].dir, mq[0].tgt);
        idle(); idle();

        // Stalled resolve is not accepted until the stall drops; pushes still accepted.
        pushB(32'h3004, 1, 32'h3800, 4'd11, 12'h333);
        applyStimulus(0, 1, 32'h3008, 0, 32'h0, 4'd12, 12'h334, 1, 1, 32'h3800, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h3800, 1);
        resolveB(1, 32'h3800);
        resolveB(0, 32'h0);
        idle();

        // Reset wins over a concurrent mispredicting resolve.
        pushB(32'h4004, 0, 32'h0, 4'd1, 12'h444);
        pushB(32'h4008, 0, 32'h0, 4'd2, 12'h445);
        applyStimulus(1, 1, 32'h400C, 0, 0, 0, 0, 1, 1, 32'h5000, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        check("rst_qerr", 32'(q_err), 32'd0);
        check("rst_full", 32'(f_full), 32'd0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
                rd = mq[0].dir;
                rt = mq[0].dir ? mq[0].tgt : 32'($urandom_range(0, 15)) << 4;
                if ($urandom_range(0, 3) == 0) rt = 32'($urandom_range(0, 15)) << 4;
            end else begin
                rd = 1'($urandom_range(0, 1));
                rt = 32'($urandom_range(0, 15)) << 4;
            end
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 1) == 1,
                          32'h8000 + (32'($urandom_range(0, 255)) << 2),
                          1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 15)) << 4,
                          4'($urandom_range(0, 15)),
                          GHR_W'($urandom),
                          $urandom_range(0, 9) < 4,
                          rd, rt,
                          $urandom_range(0, 6) == 0);
        end
        idle(); idle(); idle();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
